// File: rtl/demux2_pkg.sv
// Shared types and constants for the 1-to-2 stream demultiplexer.
package demux2_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b10
   } fifo_state_t;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry output buffer: head register drives dout, tail holds a second beat.
// Optional pop counter is built only when DEMUX2_STATS_EN is defined.
module stream_fifo2
   import demux2_pkg::*;
#(
   parameter int n = 16
`ifdef DEMUX2_STATS_EN
   ,
   parameter int CW = 8
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push,
   input  logic [n-1:0]  din,
   output logic          full,
   input  logic          pop,
   output logic          valid,
   output logic [n-1:0]  dout
`ifdef DEMUX2_STATS_EN
   ,
   output logic [CW-1:0] cnt
`endif
);

   fifo_state_t  state_q, state_d;
   logic [n-1:0] head_q, head_d;
   logic [n-1:0] tail_q, tail_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push) begin
               state_d = ONE;
               head_d  = din;
            end
         end
         ONE: begin
            // Simultaneous push and pop replaces the head in place.
            if (push && !pop) begin
               state_d = TWO;
               tail_d  = din;
            end else if (push && pop) begin
               head_d  = din;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         TWO: begin
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   assign full  = (state_q == TWO);
   assign valid = (state_q != EMPTY);
   assign dout  = head_q;

`ifdef DEMUX2_STATS_EN
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (pop) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign cnt = cnt_q;
`endif

endmodule

// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer steering each beat to output a or b.
// Define DEMUX2_STATS_EN to add per-output transfer counters cnt_a/cnt_b.
module demux2_stream
   import demux2_pkg::*;
#(
   parameter int n = 16
`ifdef DEMUX2_STATS_EN
   ,
   parameter int CW = 8
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          select,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [n-1:0]  in_data,
   output logic          a_valid,
   input  logic          a_ready,
   output logic [n-1:0]  a,
   output logic          b_valid,
   input  logic          b_ready,
   output logic [n-1:0]  b
`ifdef DEMUX2_STATS_EN
   ,
   output logic [CW-1:0] cnt_a,
   output logic [CW-1:0] cnt_b
`endif
);

   logic full_a, full_b, sel_full;
   logic push_a, push_b;

   // Ready looks only at the selected buffer's fill level, never at a_ready/b_ready.
   assign sel_full = (select == SEL_B) ? full_b : full_a;
   assign in_ready = enable && rst_n && !sel_full;
   assign push_a   = in_valid && in_ready && (select == SEL_A);
   assign push_b   = in_valid && in_ready && (select == SEL_B);

   stream_fifo2 #(
      .n (n)
`ifdef DEMUX2_STATS_EN
      ,
      .CW(CW)
`endif
   ) u_fifo_a (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push_a),
      .din  (in_data),
      .full (full_a),
      .pop  (a_valid && a_ready),
      .valid(a_valid),
      .dout (a)
`ifdef DEMUX2_STATS_EN
      ,
      .cnt  (cnt_a)
`endif
   );

   stream_fifo2 #(
      .n (n)
`ifdef DEMUX2_STATS_EN
      ,
      .CW(CW)
`endif
   ) u_fifo_b (
      .clk  (clk),
      .rst_n(rst_n),
      .push (push_b),
      .din  (in_data),
      .full (full_b),
      .pop  (b_valid && b_ready),
      .valid(b_valid),
      .dout (b)
`ifdef DEMUX2_STATS_EN
      ,
      .cnt  (cnt_b)
`endif
   );

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: directed scenarios plus a randomized
// run against a queue-based reference model of the two output channels.
module tb_demux2_stream;
   localparam int N = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0, enable = 1'b0, select = 1'b0, in_valid = 1'b0;
   logic         a_ready = 1'b0, b_ready = 1'b0;
   logic [N-1:0] in_data = '0;
   logic         in_ready, a_valid, b_valid;
   logic [N-1:0] a, b;
`ifdef DEMUX2_STATS_EN
   logic [7:0]   cnt_a, cnt_b;
   bit   [7:0]   m_cnt_a, m_cnt_b;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model: one FIFO queue per output, capacity two.
   logic [N-1:0] qa[$];
   logic [N-1:0] qb[$];

   always #5 clk = ~clk;

   demux2_stream #(
      .n (N)
`ifdef DEMUX2_STATS_EN
      ,
      .CW(8)
`endif
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .select  (select),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data (in_data),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a       (a),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b       (b)
`ifdef DEMUX2_STATS_EN
      ,
      .cnt_a   (cnt_a),
      .cnt_b   (cnt_b)
`endif
   );

   function automatic bit model_ready();
      bit room;
      room = select ? (qb.size() < 2) : (qa.size() < 2);
      return (rst_n === 1'b1) && (enable === 1'b1) && room;
   endfunction

   // Advance one clock; update the model from the inputs held before the edge.
   task automatic tick();
      bit acc, pa, pb;
      acc = model_ready() && (in_valid === 1'b1);
      pa  = (a_ready === 1'b1) && (qa.size() > 0);
      pb  = (b_ready === 1'b1) && (qb.size() > 0);
      @(posedge clk);
      if (rst_n !== 1'b1) begin
         qa.delete();
         qb.delete();
`ifdef DEMUX2_STATS_EN
         m_cnt_a = 0;
         m_cnt_b = 0;
`endif
      end else begin
         if (pa) begin
            void'(qa.pop_front());
`ifdef DEMUX2_STATS_EN
            m_cnt_a++;
`endif
         end
         if (pb) begin
            void'(qb.pop_front());
`ifdef DEMUX2_STATS_EN
            m_cnt_b++;
`endif
         end
         if (acc) begin
            if (select) qb.push_back(in_data);
            else        qa.push_back(in_data);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; in_valid = 1'b1; select = 1'b0;
      in_data = 16'hFFFF; a_ready = 1'b0; b_ready = 1'b0;
      tick();
      tick();
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b want=0", a_valid); end
      total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b want=0", b_valid); end
      total++; if (a !== 16'h0000) begin bad++; $display("FAIL reset_a got=%h want=0000", a); end
      total++; if (b !== 16'h0000) begin bad++; $display("FAIL reset_b got=%h want=0000", b); end
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", in_ready); end
      $display("test_reset: done");
   endtask

   task automatic test_routing();
      a_ready = 1'b1; b_ready = 1'b1;
      in_valid = 1'b1; select = 1'b0; in_data = 16'h8000;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL route_ready_a got=%b want=1", in_ready); end
      tick();
      select = 1'b1; in_data = 16'h0001;
      #1;
      total++; if (a_valid !== 1'b1 || a !== 16'h8000) begin bad++; $display("FAIL route_a got=%b/%h want=1/8000", a_valid, a); end
      total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL route_b_idle got=%b want=0", b_valid); end
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (b_valid !== 1'b1 || b !== 16'h0001) begin bad++; $display("FAIL route_b got=%b/%h want=1/0001", b_valid, b); end
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL route_a_drained got=%b want=0", a_valid); end
      tick();
      $display("test_routing: done");
   endtask

   task automatic test_backpressure();
      a_ready = 1'b0; b_ready = 1'b1;
      in_valid = 1'b1; select = 1'b0; in_data = 16'h0011;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept1 got=%b want=1", in_ready); end
      tick();
      in_data = 16'h0022;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept2 got=%b want=1", in_ready); end
      tick();
      in_data = 16'h0033;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b want=0", in_ready); end
      in_valid = 1'b0; select = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_other_ready got=%b want=1", in_ready); end
      // Full buffer popped on the same cycle: no accept until the next one.
      in_valid = 1'b1; select = 1'b0; a_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b0 || a !== 16'h0011) begin bad++; $display("FAIL bp_fullpop ready=%b a=%h want=0/0011", in_ready, a); end
      tick();
      #1;
      total++; if (in_ready !== 1'b1 || a !== 16'h0022) begin bad++; $display("FAIL bp_second ready=%b a=%h want=1/0022", in_ready, a); end
      tick();
      in_valid = 1'b0;
      #1;
      total++; if (a_valid !== 1'b1 || a !== 16'h0033) begin bad++; $display("FAIL bp_third got=%b/%h want=1/0033", a_valid, a); end
      tick();
      #1;
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", a_valid); end
      $display("test_backpressure: done");
   endtask

   task automatic test_enable();
      b_ready = 1'b0; select = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
      tick();
      enable = 1'b0; in_data = 16'h1234;
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL en_ready got=%b want=0", in_ready); end
      tick();
      #1;
      total++; if (b_valid !== 1'b1 || b !== 16'hBEEF) begin bad++; $display("FAIL en_hold got=%b/%h want=1/beef", b_valid, b); end
      b_ready = 1'b1;
      tick();
      #1;
      total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL en_drain got=%b want=0", b_valid); end
      in_valid = 1'b0; enable = 1'b1;
      $display("test_enable: done");
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst_n    = ($urandom_range(0, 63) != 0);
         enable   = ($urandom_range(0, 7) != 0);
         select   = 1'($urandom);
         in_valid = 1'($urandom);
         a_ready  = ($urandom_range(0, 3) != 0);
         b_ready  = ($urandom_range(0, 2) == 0);
         in_data  = 16'($urandom);
         #1;
         total++; if (in_ready !== model_ready()) begin bad++; $display("FAIL rnd_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, model_ready()); end
         total++; if (a_valid !== (qa.size() != 0)) begin bad++; $display("FAIL rnd_a_valid cyc=%0d got=%b want=%b", cyc, a_valid, qa.size() != 0); end
         total++; if (b_valid !== (qb.size() != 0)) begin bad++; $display("FAIL rnd_b_valid cyc=%0d got=%b want=%b", cyc, b_valid, qb.size() != 0); end
         if (qa.size() != 0) begin
            total++; if (a !== qa[0]) begin bad++; $display("FAIL rnd_a_data cyc=%0d got=%h want=%h", cyc, a, qa[0]); end
         end
         if (qb.size() != 0) begin
            total++; if (b !== qb[0]) begin bad++; $display("FAIL rnd_b_data cyc=%0d got=%h want=%h", cyc, b, qb[0]); end
         end
`ifdef DEMUX2_STATS_EN
         total++; if (cnt_a !== m_cnt_a || cnt_b !== m_cnt_b) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d/%0d want=%0d/%0d", cyc, cnt_a, cnt_b, m_cnt_a, m_cnt_b); end
`endif
         tick();
      end
      rst_n = 1'b1; enable = 1'b1; in_valid = 1'b0;
      $display("test_random: done");
   endtask

`ifdef DEMUX2_STATS_EN
   task automatic test_stats();
      rst_n = 1'b0; in_valid = 1'b0;
      tick();
      rst_n = 1'b1; enable = 1'b1; select = 1'b0; in_valid = 1'b1;
      a_ready = 1'b1; b_ready = 1'b1;
      for (int i = 0; i < 258; i++) begin
         in_data = 16'(i);
         tick();
      end
      in_valid = 1'b0;
      #1;
      total++; if (cnt_a !== 8'd1 || cnt_b !== 8'd0) begin bad++; $display("FAIL stats_wrap got=%0d/%0d want=1/0", cnt_a, cnt_b); end
      rst_n = 1'b0;
      tick();
      #1;
      total++; if (cnt_a !== 8'd0 || cnt_b !== 8'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL stats_reset got=%0d/%0d/%b want=0/0/0", cnt_a, cnt_b, a_valid); end
      rst_n = 1'b1;
      $display("test_stats: done");
   endtask
`endif

   initial begin
      @(negedge clk);
      test_reset();
      test_routing();
      test_backpressure();
      test_enable();
      test_random();
`ifdef DEMUX2_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
